// File: rtl/uart_apb_master.sv
// APB initiator: turns a valid/ready command stream into APB SETUP/ACCESS transfers.
// Latency: rsp_valid 3 cycles after the accept cycle for a zero-wait slave, +1 per wait state.
// Backpressure: cmd_ready is high in IDLE and in the completing ACCESS cycle only.
module uart_apb_master #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  // A zero TIMEOUT still needs a 1-bit counter so the logic stays legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  cmd_ready_c;

  // Next-state, command capture and response generation.
  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    wait_cnt_d    = wait_cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = 1'b0;
    cmd_ready_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_c = 1'b1;
        if (cmd_valid) begin
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        wait_cnt_d = '0;
        state_d    = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          // Completion wins over a timeout landing on the same edge.
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          cmd_ready_c   = 1'b1;
          state_d       = cmd_valid ? ST_SETUP : ST_IDLE;
        end else if ((TIMEOUT != 0) && (wait_cnt_q == CNT_LAST)) begin
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          state_d       = ST_IDLE;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Address/data registers only move on an accepted command, so they stay
    // stable for the whole transfer and keep their last value in IDLE.
    if (cmd_valid && cmd_ready_c) begin
      paddr_d  = cmd_addr;
      pwrite_d = cmd_write;
      pwdata_d = cmd_wdata;
    end
  end

  // APB strobes are registered straight from the next state.
  always_comb begin
    psel_d    = (state_d != ST_IDLE);
    penable_d = (state_d == ST_ACCESS);
  end

  // State and output registers; reset drops the bus immediately.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= ST_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      wait_cnt_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      wait_cnt_q    <= wait_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_c;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_uart_apb_master.sv
// Directed bench for uart_apb_master with a small behavioural APB register slave.
// Slave inserts `ws` wait states per ACCESS (ws large = pready stuck low).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_uart_apb_master;

  logic       pclk;
  logic       presetn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;
  logic       psel;
  logic       penable;
  logic [1:0] paddr;
  logic       pwrite;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Slave model state.
  logic [7:0] mem [4] = '{8'h00, 8'h00, 8'hC3, 8'h77};
  int ws = 0;
  int acc_cnt = 0;

  uart_apb_master #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .TIMEOUT(16)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  assign prdata = mem[paddr];
  assign pready = (psel && penable) ? (acc_cnt == ws) : 1'b1;

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command from a falling edge, return at the falling edge where
  // rsp_valid is seen. lat counts cycles after the accept cycle (SETUP = 1).
  task automatic run_cmd(input logic w, input logic [1:0] a, input logic [7:0] d,
                         output int lat, output int acc, output logic [7:0] rd,
                         output logic to, output logic got);
    int guard;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    #1;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge pclk);
      #1;
      guard++;
    end
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b0;
    lat = 0; acc = 0; rd = 8'h00; to = 1'b0; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      lat++;
      if (rsp_valid) begin
        got = 1'b1;
        rd  = rsp_rdata;
        to  = rsp_timeout;
        break;
      end
      if (psel && penable) acc++;
      @(negedge pclk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, acc;
    logic [7:0] rd;
    logic to, got;

    presetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 2'd0;
    cmd_wdata = 8'h00;
    repeat (2) @(negedge pclk);

    // Reset state.
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    presetn = 1'b1;
    @(negedge pclk);

    // Zero-wait write of 0x5A to addr 0, checked cycle by cycle.
    ws = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd0; cmd_wdata = 8'h5A;
    #1 chk("wr_accept_ready", cmd_ready, 1);
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b0;
    chk("wr_setup_psel", psel, 1);
    chk("wr_setup_penable", penable, 0);
    chk("wr_setup_cmd_ready", cmd_ready, 0);
    chk("wr_setup_bus", {paddr, pwrite, pwdata}, {2'd0, 1'b1, 8'h5A});
    @(negedge pclk);
    chk("wr_access_psel", psel, 1);
    chk("wr_access_penable", penable, 1);
    chk("wr_access_bus", {paddr, pwrite, pwdata}, {2'd0, 1'b1, 8'h5A});
    @(negedge pclk);
    chk("wr_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, {1'b1, 1'b0, 8'h00});
    chk("wr_done_psel", {psel, penable}, 2'b00);
    @(negedge pclk);
    chk("wr_rsp_one_cycle", rsp_valid, 0);
    chk("wr_slave_mem", mem[0], 8'h5A);

    // Read addr 2 (0xC3) with 2 wait states.
    ws = 2;
    run_cmd(1'b0, 2'd2, 8'hFF, lat, acc, rd, to, got);
    chk("rd_got", got, 1);
    chk("rd_access_cycles", acc, 3);
    chk("rd_latency", lat, 5);
    chk("rd_data", rd, 8'hC3);
    chk("rd_timeout", to, 0);

    // Back-to-back: write 0x11 to addr 1, then read addr 1.
    ws = 0;
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd1; cmd_wdata = 8'h11;
    @(posedge pclk);
    @(negedge pclk);
    cmd_write = 1'b0; cmd_wdata = 8'h00;
    chk("b2b_setup1", {psel, penable}, 2'b10);
    @(negedge pclk);
    chk("b2b_access1", {psel, penable}, 2'b11);
    chk("b2b_access1_bus", {paddr, pwrite, pwdata}, {2'd1, 1'b1, 8'h11});
    chk("b2b_access1_ready", cmd_ready, 1);
    @(negedge pclk);
    cmd_valid = 1'b0;
    chk("b2b_setup2", {psel, penable}, 2'b10);
    chk("b2b_setup2_bus", {paddr, pwrite}, {2'd1, 1'b0});
    chk("b2b_rsp1", {rsp_valid, rsp_timeout, rsp_rdata}, {1'b1, 1'b0, 8'h00});
    @(negedge pclk);
    chk("b2b_access2", {psel, penable}, 2'b11);
    chk("b2b_access2_norsp", rsp_valid, 0);
    @(negedge pclk);
    chk("b2b_rsp2", {rsp_valid, rsp_timeout, rsp_rdata}, {1'b1, 1'b0, 8'h11});
    chk("b2b_idle", psel, 0);

    // Timeout with pready stuck low.
    @(negedge pclk);
    ws = 1000;
    run_cmd(1'b0, 2'd3, 8'h00, lat, acc, rd, to, got);
    chk("to_got", got, 1);
    chk("to_access_cycles", acc, 16);
    chk("to_flag", to, 1);
    chk("to_rdata", rd, 8'h00);
    chk("to_idle_psel", psel, 0);
    chk("to_idle_ready", cmd_ready, 1);

    // pready rising in the 16th ACCESS cycle completes normally.
    @(negedge pclk);
    ws = 15;
    run_cmd(1'b0, 2'd3, 8'h00, lat, acc, rd, to, got);
    chk("late_got", got, 1);
    chk("late_access_cycles", acc, 16);
    chk("late_flag", to, 0);
    chk("late_rdata", rd, 8'h77);

    // Reset during the 3rd ACCESS wait cycle.
    @(negedge pclk);
    ws = 10;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd2;
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge pclk);
    chk("mid_access_wait", {psel, penable, pready}, 3'b110);
    #2 presetn = 1'b0;
    #1;
    chk("mid_rst_bus", {psel, penable}, 2'b00);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk("mid_rst_norsp", rsp_valid, 0);
    end
    presetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge pclk);
      chk("post_rst_norsp", {rsp_valid, psel}, 2'b00);
    end
    ws = 0;
    run_cmd(1'b1, 2'd0, 8'h3C, lat, acc, rd, to, got);
    chk("post_rst_got", got, 1);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_rsp", {to, rd}, {1'b0, 8'h00});
    @(negedge pclk);
    chk("post_rst_mem", mem[0], 8'h3C);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
